// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver clocked at 16x baud: 3-sample majority vote at mid-bit,
// single-entry vld/rdy holding register toward the debug command processor.
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    input  logic                 rdy_rx,
    output logic                 vld_rx,
    output logic [DATA_BITS-1:0] d_rx,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] M0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] M1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] M2     = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   samp_a_q, samp_b_q;
    logic                   maj, mid, deliver, ferr_d;

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign busy  = (state_q != IDLE);
    assign mid   = (tick_q == M2);
    // Third sample is rxd_s itself, taken in the decision cycle.
    assign maj   = (samp_a_q & samp_b_q) | (rxd_s & (samp_a_q | samp_b_q));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q   <= '1;
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync_q   <= SYNC_STAGES'({sync_q, rxd});
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            if (tick_q == M0) samp_a_q <= rxd_s;
            if (tick_q == M1) samp_b_q <= rxd_s;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        tick_d  = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (tick_q == T_LAST) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                // LSB arrives first: shift right, new bit enters at the MSB.
                if (mid) shreg_d = DATA_BITS'({maj, shreg_q} >> 1);
                if (tick_q == T_LAST) begin
                    if (bit_q == B_LAST) state_d = STOP;
                    else                 bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is caught early.
                if (mid) begin
                    state_d = maj ? IDLE : BREAK;
                    deliver = maj;
                    ferr_d  = ~maj;
                end
            end
            BREAK: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_rx    <= 1'b0;
            d_rx      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!vld_rx || rdy_rx) begin
                    d_rx   <= shreg_q;
                    vld_rx <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (vld_rx && rdy_rx) begin
                vld_rx <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: a waveform is built up front, an
// offline frame-level model predicts every output per cycle, then the DUT is run.
module tb_uart_rx_os16;
    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int MAXC = 20000;
    localparam int LAT  = 156;  // first low cycle on rxd -> first cycle with vld_rx=1

    logic          clk = 1'b0;
    logic          rstn, rxd, rdy_rx;
    logic          vld_rx, frame_err, overrun, busy;
    logic [DB-1:0] d_rx;

    always #5 clk = ~clk;

    uart_rx_os16 #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .rdy_rx(rdy_rx),
        .vld_rx(vld_rx), .d_rx(d_rx), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    // stimulus per cycle, model intermediates, expected and observed outputs
    bit         line[MAXC], rdyv[MAXC], rstv[MAXC];
    bit         sl[MAXC], dlv[MAXC], fev[MAXC], bm[MAXC];
    logic [7:0] dbyte[MAXC];
    bit         e_vld[MAXC], e_fe[MAXC], e_ov[MAXC], e_busy[MAXC];
    logic [7:0] e_d[MAXC];
    logic       o_vld[MAXC], o_fe[MAXC], o_ov[MAXC], o_busy[MAXC];
    logic [7:0] o_d[MAXC];

    int n = 0;
    int errors = 0;
    int checks = 0;
    bit cur_rdy = 1'b1;
    bit rdy_rand = 1'b0;

    int e1a, e1b, e2, e3, e4, e4b, e5a, e5b, q5, e6, r6, e6b, ef, gb;
    logic [7:0] rb;
    bit sok;

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
        end
    endtask

    task automatic put(input bit v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n < MAXC) begin
                line[n] = v;
                rdyv[n] = rdy_rand ? ($urandom_range(3) == 0) : cur_rdy;
                rstv[n] = 1'b1;
                n++;
            end
        end
    endtask

    task automatic put_rst(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n < MAXC) begin
                line[n] = 1'b1;
                rdyv[n] = cur_rdy;
                rstv[n] = 1'b0;
                n++;
            end
        end
    endtask

    task automatic put_frame(input logic [7:0] b, input bit stop, output int e0);
        e0 = n;
        put(1'b0, OS);
        for (int i = 0; i < DB; i++) put(b[i], OS);
        put(stop, OS);
    endtask

    function automatic bit getsl(input int i);
        return (i < n) ? sl[i] : 1'b1;
    endfunction

    // majority of the three mid-bit samples of frame bit b (0 = start) for a frame whose tick 0 is cycle t
    function automatic bit samp(input int t, input int b);
        int cnt;
        cnt = int'(getsl(t + OS*b + OS/2 - 1)) + int'(getsl(t + OS*b + OS/2)) + int'(getsl(t + OS*b + OS/2 + 1));
        return cnt >= 2;
    endfunction

    task automatic build_model();
        bit s0, s1, v, fe, ov, stop_v, fs;
        logic [7:0] d, by;
        int pos, k, t, dcy, last, nxt, r;
        s0 = 1'b1;
        s1 = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (!rstv[c]) begin
                s0 = 1'b1;
                s1 = 1'b1;
            end else begin
                s1 = s0;
                s0 = line[c];
            end
            sl[c] = s1; dlv[c] = 1'b0; fev[c] = 1'b0; bm[c] = 1'b0; dbyte[c] = 8'h00;
        end
        // frame scanner on the synchronized line
        pos = 0;
        while (pos < n) begin
            k = pos;
            while (k < n && sl[k]) k++;
            if (k >= n) break;
            t = k + 1;
            fs = samp(t, 0);
            by = 8'h00;
            stop_v = 1'b0;
            dcy = t + OS*(DB + 1) + OS/2 + 1;
            if (fs) begin
                last = t + OS/2 + 1;
                nxt = last + 1;
            end else begin
                for (int i = 0; i < DB; i++) by[i] = samp(t, i + 1);
                stop_v = samp(t, DB + 1);
                if (stop_v) begin
                    last = dcy;
                    nxt = dcy + 1;
                end else begin
                    last = dcy + 1;
                    while (!getsl(last)) last++;
                    nxt = last + 1;
                end
            end
            r = -1;
            for (int c = t; c <= last && c < n; c++) begin
                if (!rstv[c]) begin
                    r = c;
                    break;
                end
            end
            if (r >= 0) begin
                last = r - 1;
                nxt = r;
            end
            for (int c = t; c <= last && c < n; c++) bm[c] = 1'b1;
            if (!fs && (r < 0 || r > dcy) && dcy < n) begin
                if (stop_v) begin
                    dlv[dcy] = 1'b1;
                    dbyte[dcy] = by;
                end else begin
                    fev[dcy] = 1'b1;
                end
            end
            pos = nxt;
        end
        // holding register and pulse outputs
        v = 1'b0; d = 8'h00;
        for (int c = 0; c < n; c++) begin
            fe = 1'b0;
            ov = 1'b0;
            if (!rstv[c]) begin
                v = 1'b0;
                d = 8'h00;
            end else if (c > 0) begin
                fe = fev[c-1];
                if (dlv[c-1]) begin
                    if (v && !rdyv[c]) ov = 1'b1;
                    else d = dbyte[c-1];
                    v = 1'b1;
                end else if (v && rdyv[c]) begin
                    v = 1'b0;
                end
            end
            e_vld[c] = v; e_d[c] = d; e_fe[c] = fe; e_ov[c] = ov;
            e_busy[c] = bm[c] && rstv[c];
        end
    endtask

    function automatic int vld_rises(input int a, input int b);
        int cnt = 0;
        for (int c = a; c < b && c < n; c++)
            if (o_vld[c] === 1'b1 && (c == 0 || o_vld[c-1] !== 1'b1)) cnt++;
        return cnt;
    endfunction

    function automatic int pulses(input bit sel_fe, input int a, input int b);
        int cnt = 0;
        for (int c = a; c < b && c < n; c++)
            if ((sel_fe ? o_fe[c] : o_ov[c]) === 1'b1) cnt++;
        return cnt;
    endfunction

    initial begin
        rstn = 1'b0; rxd = 1'b1; rdy_rx = 1'b0;

        put_rst(5);
        put(1'b1, 20);
        // back-to-back bytes, consumer always ready
        put_frame(8'h55, 1'b1, e1a);
        put_frame(8'hA5, 1'b1, e1b);
        put(1'b1, 30);
        // 4-cycle glitch: false start
        e2 = n;
        put(1'b0, 4);
        put(1'b1, 40);
        // one corrupted sample in data bit 2
        put_frame(8'h3C, 1'b1, e3);
        line[e3 + OS*3 + OS/2 + 1] = ~line[e3 + OS*3 + OS/2 + 1];
        put(1'b1, 30);
        // bad stop bit followed by a long break, then a good frame
        put_frame(8'h81, 1'b0, e4);
        put(1'b0, OS*40);
        put(1'b1, 30);
        put_frame(8'h12, 1'b1, e4b);
        put(1'b1, 30);
        // overrun with consumer stalled, then drain
        cur_rdy = 1'b0;
        put_frame(8'h11, 1'b1, e5a);
        put_frame(8'h22, 1'b1, e5b);
        put(1'b1, 20);
        cur_rdy = 1'b1;
        q5 = n;
        put(1'b1, 30);
        // reset in the middle of a frame
        e6 = n;
        put(1'b0, OS);
        put(1'b1, OS); put(1'b1, OS); put(1'b1, OS);
        put(1'b0, 5);
        r6 = n;
        put_rst(6);
        put(1'b1, 40);
        put_frame(8'h5A, 1'b1, e6b);
        put(1'b1, 40);
        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            rdy_rand = ($urandom_range(2) != 0);
            put(1'b1, int'($urandom_range(30)));
            if ($urandom_range(7) == 0) begin
                put(1'b0, int'($urandom_range(6, 1)));
                put(1'b1, 20);
            end
            rb = 8'($urandom);
            sok = ($urandom_range(7) != 0);
            put_frame(rb, sok, ef);
            if ($urandom_range(3) == 0) begin
                gb = int'($urandom_range(DB, 1));
                line[ef + OS*gb + OS/2 + int'($urandom_range(2))] = ~line[ef + OS*gb + OS/2];
            end
            if (!sok) put(1'b0, int'($urandom_range(50)));
        end
        rdy_rand = 1'b0;
        put(1'b1, 200);

        build_model();

        // run and compare every cycle
        for (int c = 0; c < n; c++) begin
            rxd = line[c];
            rdy_rx = rdyv[c];
            rstn = rstv[c];
            @(posedge clk);
            #1;
            o_vld[c] = vld_rx; o_d[c] = d_rx; o_fe[c] = frame_err; o_ov[c] = overrun; o_busy[c] = busy;
            check("vld_rx", c, 8'(vld_rx), 8'(e_vld[c]));
            check("d_rx", c, d_rx, e_d[c]);
            check("frame_err", c, 8'(frame_err), 8'(e_fe[c]));
            check("overrun", c, 8'(overrun), 8'(e_ov[c]));
            check("busy", c, 8'(busy), 8'(e_busy[c]));
            @(negedge clk);
        end

        // hand-computed expectations
        check("reset_vld", 2, 8'(o_vld[2]), 8'd0);
        check("reset_busy", 2, 8'(o_busy[2]), 8'd0);
        check("reset_d", 2, o_d[2], 8'h00);
        check("model_first_vld", e1a + LAT, 8'(e_vld[e1a + LAT]), 8'd1);
        check("first_vld_early", e1a + LAT - 1, 8'(o_vld[e1a + LAT - 1]), 8'd0);
        check("first_vld", e1a + LAT, 8'(o_vld[e1a + LAT]), 8'd1);
        check("first_byte", e1a + LAT, o_d[e1a + LAT], 8'h55);
        check("first_vld_drop", e1a + LAT + 1, 8'(o_vld[e1a + LAT + 1]), 8'd0);
        check("second_byte", e1b + LAT, o_d[e1b + LAT], 8'hA5);
        check("b2b_vld_count", e1a, 8'(vld_rises(e1a, e1b + LAT + 5)), 8'd2);
        check("false_start_busy", e2 + 2, 8'(o_busy[e2 + 2]), 8'd1);
        check("false_start_idle", e2 + 12, 8'(o_busy[e2 + 12]), 8'd0);
        check("false_start_vld", e2, 8'(vld_rises(e2, e3)), 8'd0);
        check("false_start_fe", e2, 8'(pulses(1'b1, e2, e3)), 8'd0);
        check("model_majority", e3 + LAT, e_d[e3 + LAT], 8'h3C);
        check("majority_byte", e3 + LAT, o_d[e3 + LAT], 8'h3C);
        check("break_fe_pulse", e4 + LAT, 8'(o_fe[e4 + LAT]), 8'd1);
        check("break_fe_count", e4, 8'(pulses(1'b1, e4, e4b + LAT + 5)), 8'd1);
        check("break_vld_count", e4, 8'(vld_rises(e4, e4b + LAT + 5)), 8'd1);
        check("after_break_byte", e4b + LAT, o_d[e4b + LAT], 8'h12);
        check("model_overrun", e5b + LAT, 8'(e_ov[e5b + LAT]), 8'd1);
        check("overrun_pulse", e5b + LAT, 8'(o_ov[e5b + LAT]), 8'd1);
        check("overrun_count", e5a, 8'(pulses(1'b0, e5a, q5 + 20)), 8'd1);
        check("overrun_held", q5 - 1, o_d[q5 - 1], 8'h11);
        check("stall_vld", q5 - 1, 8'(o_vld[q5 - 1]), 8'd1);
        check("drain_vld", q5, 8'(o_vld[q5]), 8'd0);
        check("drain_d", q5, o_d[q5], 8'h11);
        check("midreset_vld", r6 + 1, 8'(o_vld[r6 + 1]), 8'd0);
        check("midreset_busy", r6 + 1, 8'(o_busy[r6 + 1]), 8'd0);
        check("midreset_d", r6 + 1, o_d[r6 + 1], 8'h00);
        check("after_reset_count", e6, 8'(vld_rises(e6, e6b + LAT + 5)), 8'd1);
        check("after_reset_byte", e6b + LAT, o_d[e6b + LAT], 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
8N1 UART receiver running on the 16x-baud clock. It is the receive-direction counterpart of uart_tx. It recovers bytes from the serial line using 3-sample majority voting at mid-bit and presents each byte to the debug command processor (DCP) over a vld/rdy handshake. A single-entry output holding register decouples the serial timing from the consumer.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first
OVERSAMPLE, 16, clk cycles per bit; must be an even value of 8 or more
SYNC_STAGES, 2, flops in the rxd synchronizer chain

Ports:
clk  input  1  16x-baud clock (div_16_9600_clk in SDU)
rstn  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, asynchronous to clk
rdy_rx  input  1  consumer ready; a transfer occurs in any cycle where vld_rx and rdy_rx are both high
vld_rx  output  1  d_rx holds an unconsumed byte
d_rx  output  DATA_BITS  received byte
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: a new byte was dropped because the holding register was full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rstn=0):
  - All synchronizer flops reset to 1.
  - State=IDLE; tick counter and bit counter = 0.
  - Outputs: vld_rx=0, d_rx=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame. No output is produced.
- rxd_s is rxd after SYNC_STAGES flops. All decisions below use rxd_s only.
- Sample points: M0=OVERSAMPLE/2-1, M1=OVERSAMPLE/2, M2=OVERSAMPLE/2+1 (7, 8, 9 at default). The bit value is the majority of the three samples; it is decided in the cycle tick=M2.
- State machine:
  - IDLE: when rxd_s=0, go to START with tick=0. That cycle is called S.
  - START: tick counts 0..OVERSAMPLE-1 and wraps.
    - Majority=1 at M2: false start. Return to IDLE at the next cycle; no pulse.
    - Majority=0: continue to the end of the bit, then go to DATA with bit=0.
  - DATA: each bit lasts OVERSAMPLE ticks.
    - At M2 the majority is shifted in at the MSB of the shift register (right shift), so after DATA_BITS shifts the byte is LSB-first correct.
    - At tick=OVERSAMPLE-1 of bit DATA_BITS-1, go to STOP.
  - STOP: decision at M2, then immediate return to IDLE without waiting for end of the bit. This allows the next start edge to be caught early.
    - Majority=1: deliver the byte.
    - Majority=0: frame_err pulses at the next cycle and the byte is discarded. Go to BREAK instead of IDLE.
  - BREAK: wait until rxd_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency, default parameters:
  - Stop decision at S+OVERSAMPLE*(DATA_BITS+1)+M2 = S+153.
  - vld_rx=1 and d_rx valid from S+154.
- Holding register, on delivery:
  - vld_rx=0: load d_rx and set vld_rx=1.
  - vld_rx=1 and rdy_rx=1 in the same cycle: load the new byte; vld_rx stays 1; no overrun.
  - vld_rx=1 and rdy_rx=0: new byte dropped; d_rx is unchanged; overrun pulses for one cycle.
  - Handshake with no delivery: vld_rx=0 at the next cycle. d_rx retains its value.
  - d_rx is stable while vld_rx=1 and rdy_rx=0.
- rdy_rx has no effect on the receive state machine. Reception never stalls.
- frame_err and overrun never assert in the same cycle as each other for the same frame.

Test Plan:
- Send 0x55 then 0xA5 back to back with rdy_rx=1 -> vld_rx pulses once per byte, d_rx=0x55 then 0xA5, first vld_rx at S+154, no error pulses.
- Drive rxd low for 4 clk cycles and then high -> returns to IDLE after the start check, busy deasserts, no vld_rx, no frame_err.
- Send 0x3C with the single sample at tick 8 of bit 2 inverted -> d_rx=0x3C (majority corrects).
- Send 0x81 with stop bit forced 0, then hold rxd low for 40 bit times, then release -> exactly one frame_err pulse, vld_rx stays 0, next frame 0x12 received correctly.
- rdy_rx=0; send 0x11 then 0x22 -> d_rx=0x11, vld_rx=1, one overrun pulse at the 0x22 delivery. Then raise rdy_rx -> one transfer of 0x11, vld_rx drops.
- Assert rstn=0 mid-DATA of 0x77, release, send 0x5A -> all outputs 0 during reset, only 0x5A delivered.
